// File: rtl/dlx_alu.sv
// rtl/dlx_alu.sv - registered arithmetic/logic/shift unit fed by the execute stage
module dlx_alu #(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_ex,
  input  logic [2:0]                opselect,
  input  logic [2:0]                operation,
  input  logic                      enable_arith,
  input  logic                      enable_shift,
  input  logic [REGISTER_WIDTH-1:0] aluin1,
  input  logic [REGISTER_WIDTH-1:0] aluin2,
  input  logic [4:0]                shift_number,
  output logic [REGISTER_WIDTH-1:0] aluout,
  output logic                      carry
);

  localparam int W = REGISTER_WIDTH;

  localparam logic [2:0] SHIFT_REG   = 3'b000;
  localparam logic [2:0] ARITH_LOGIC = 3'b001;
  localparam logic [2:0] MEM_WRITE   = 3'b100;
  localparam logic [2:0] MEM_READ    = 3'b101;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_HADD = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_LHG  = 3'b111;

  localparam logic [2:0] SH_LEFT_LOG  = 3'b000;
  localparam logic [2:0] SH_LEFT_ART  = 3'b001;
  localparam logic [2:0] SH_RIGHT_LOG = 3'b010;
  localparam logic [2:0] SH_RIGHT_ART = 3'b011;

  logic [W-1:0] aluout_q, aluout_d;
  logic         carry_q, carry_d;
  logic         upd;

  logic [W:0]   full_sum;
  logic [W:0]   full_diff;
  logic [16:0]  half_sum;

  // Shared adders: full-width sum/difference with the extra bit as carry/borrow, and the low-half sum
  always_comb begin
    full_sum  = {1'b0, aluin1} + {1'b0, aluin2};
    full_diff = {1'b0, aluin1} - {1'b0, aluin2};
    half_sum  = {1'b0, aluin1[15:0]} + {1'b0, aluin2[15:0]};
  end

  // Decode the class, qualify with the matching enable and select the next result; unmatched cases hold
  always_comb begin
    upd      = 1'b0;
    aluout_d = aluout_q;
    carry_d  = carry_q;
    if (enable_ex) begin
      case (opselect)
        ARITH_LOGIC: begin
          if (enable_arith) begin
            upd     = 1'b1;
            carry_d = 1'b0;
            case (operation)
              OP_ADD: begin
                aluout_d = full_sum[W-1:0];
                carry_d  = full_sum[W];
              end
              OP_HADD: begin
                aluout_d = {{(W-16){half_sum[15]}}, half_sum[15:0]};
                carry_d  = half_sum[16];
              end
              OP_SUB: begin
                aluout_d = full_diff[W-1:0];
                carry_d  = full_diff[W];
              end
              OP_NOT: aluout_d = ~aluin2;
              OP_AND: aluout_d = aluin1 & aluin2;
              OP_OR:  aluout_d = aluin1 | aluin2;
              OP_XOR: aluout_d = aluin1 ^ aluin2;
              OP_LHG: aluout_d = {aluin2[15:0], {(W-16){1'b0}}};
              default: aluout_d = aluout_q;
            endcase
          end
        end
        MEM_WRITE, MEM_READ: begin
          // Address generation ignores the operation field
          if (enable_arith) begin
            upd      = 1'b1;
            aluout_d = full_sum[W-1:0];
            carry_d  = 1'b0;
          end
        end
        SHIFT_REG: begin
          // Only the four defined shift codes update; codes 1xx leave the result held
          if (enable_shift && !operation[2]) begin
            upd     = 1'b1;
            carry_d = 1'b0;
            case (operation)
              SH_LEFT_LOG, SH_LEFT_ART: aluout_d = aluin1 << shift_number;
              SH_RIGHT_LOG:             aluout_d = aluin1 >> shift_number;
              SH_RIGHT_ART:             aluout_d = W'($signed(aluin1) >>> shift_number);
              default:                  aluout_d = aluout_q;
            endcase
          end
        end
        default: upd = 1'b0;
      endcase
    end
  end

  // Result registers: reset clears, otherwise load only on an updating cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      aluout_q <= '0;
      carry_q  <= 1'b0;
    end else if (upd) begin
      aluout_q <= aluout_d;
      carry_q  <= carry_d;
    end
  end

  assign aluout = aluout_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_dlx_alu.sv
// tb/tb_dlx_alu.sv - scoreboard testbench for dlx_alu
module tb_dlx_alu;

  logic        clk;
  logic        rst;
  logic        enable_ex;
  logic [2:0]  opselect;
  logic [2:0]  operation;
  logic        enable_arith;
  logic        enable_shift;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [4:0]  shift_number;
  logic [31:0] aluout;
  logic        carry;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic [32:0] last_exp;
  bit          last_valid = 0;

  dlx_alu #(.REGISTER_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .enable_ex(enable_ex), .opselect(opselect),
    .operation(operation), .enable_arith(enable_arith), .enable_shift(enable_shift),
    .aluin1(aluin1), .aluin2(aluin2), .shift_number(shift_number),
    .aluout(aluout), .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: returns {carry, result} for one cycle given the previous state
  function automatic logic [32:0] ref_alu(input logic r, input logic ex, input logic [2:0] os,
                                          input logic [2:0] op, input logic ea, input logic es,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] n, input logic [32:0] prev);
    logic [32:0] t;
    logic [16:0] h;
    if (!r) return 33'd0;
    if (!ex) return prev;
    if ((os == 3'b100 || os == 3'b101) && ea) return {1'b0, a + b};
    if (os == 3'b001 && ea) begin
      case (op)
        3'd0: begin t = {1'b0, a} + {1'b0, b}; return t; end
        3'd1: begin h = a[15:0] + b[15:0] + 17'd0; h = {1'b0, a[15:0]} + {1'b0, b[15:0]};
                    return {h[16], {16{h[15]}}, h[15:0]}; end
        3'd2: return {(a < b), a - b};
        3'd3: return {1'b0, ~b};
        3'd4: return {1'b0, a & b};
        3'd5: return {1'b0, a | b};
        3'd6: return {1'b0, a ^ b};
        default: return {1'b0, b[15:0], 16'h0};
      endcase
    end
    if (os == 3'b000 && es && op < 3'd4) begin
      case (op)
        3'd0, 3'd1: return {1'b0, a << n};
        3'd2: return {1'b0, a >> n};
        default: return {1'b0, 32'($signed(a) >>> n)};
      endcase
    end
    return prev;
  endfunction

  // One clock: drive inputs, check outputs unchanged before the edge, push expectation, pop after the edge
  task automatic step(input string nm, input logic r, input logic ex, input logic [2:0] os,
                      input logic [2:0] op, input logic ea, input logic es,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] n,
                      input logic [32:0] expv);
    logic [32:0] e;
    string       en;
    rst = r; enable_ex = ex; opselect = os; operation = op;
    enable_arith = ea; enable_shift = es; aluin1 = a; aluin2 = b; shift_number = n;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    #1;
    if (last_valid) begin
      checks++;
      if ({carry, aluout} !== last_exp) begin
        errors++;
        $display("FAIL %s_pre_edge: got carry=%0b aluout=%h, want carry=%0b aluout=%h",
                 nm, carry, aluout, last_exp[32], last_exp[31:0]);
      end
    end
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    en = name_q.pop_front();
    checks++;
    if ({carry, aluout} !== e) begin
      errors++;
      $display("FAIL %s: got carry=%0b aluout=%h, want carry=%0b aluout=%h",
               en, carry, aluout, e[32], e[31:0]);
    end
    last_exp   = e;
    last_valid = 1;
  endtask

  task automatic test_reset;
    step("reset_add", 0, 1, 3'b001, 3'd0, 1, 0, 32'd5, 32'd7, 5'd0, 33'd0);
    step("first_add", 1, 1, 3'b001, 3'd0, 1, 0, 32'd5, 32'd7, 5'd0, {1'b0, 32'd12});
    for (int i = 0; i < 5; i++)
      step("hold_no_ex", 1, 0, 3'b001, 3'd0, 1, 0, 32'd100 + i, 32'd9, 5'd0, {1'b0, 32'd12});
    step("reset_while_held", 0, 0, 3'b001, 3'd0, 1, 0, 32'd1, 32'd1, 5'd0, 33'd0);
    step("after_reset", 1, 1, 3'b001, 3'd6, 1, 0, 32'hF0F0_0000, 32'h0FF0_1234, 5'd0,
         {1'b0, 32'hFF00_1234});
  endtask

  task automatic test_carry;
    step("add_carry", 1, 1, 3'b001, 3'd0, 1, 0, 32'hFFFF_FFFF, 32'd1, 5'd0, {1'b1, 32'h0});
    step("sub_borrow", 1, 1, 3'b001, 3'd2, 1, 0, 32'd3, 32'd5, 5'd0, {1'b1, 32'hFFFF_FFFE});
    step("sub_noborrow", 1, 1, 3'b001, 3'd2, 1, 0, 32'd5, 32'd3, 5'd0, {1'b0, 32'd2});
    step("not", 1, 1, 3'b001, 3'd3, 1, 0, 32'd0, 32'h1234_5678, 5'd0, {1'b0, 32'hEDCB_A987});
  endtask

  task automatic test_hadd_lhg;
    step("hadd_carry", 1, 1, 3'b001, 3'd1, 1, 0, 32'h0000_8000, 32'h0000_8000, 5'd0, {1'b1, 32'h0});
    step("hadd_sign", 1, 1, 3'b001, 3'd1, 1, 0, 32'h0000_7FFF, 32'd1, 5'd0, {1'b0, 32'hFFFF_8000});
    step("lhg", 1, 1, 3'b001, 3'd7, 1, 0, 32'h1111_1111, 32'h0000_ABCD, 5'd0, {1'b0, 32'hABCD_0000});
  endtask

  task automatic test_shift;
    step("sra4", 1, 1, 3'b000, 3'd3, 0, 1, 32'h8000_00F0, 32'd0, 5'd4, {1'b0, 32'hF800_000F});
    step("srl4", 1, 1, 3'b000, 3'd2, 0, 1, 32'h8000_00F0, 32'd0, 5'd4, {1'b0, 32'h0800_000F});
    step("sll31", 1, 1, 3'b000, 3'd0, 0, 1, 32'h8000_00F0, 32'd0, 5'd31, {1'b0, 32'h0});
    step("sla0", 1, 1, 3'b000, 3'd1, 0, 1, 32'h8000_00F0, 32'd0, 5'd0, {1'b0, 32'h8000_00F0});
  endtask

  task automatic test_gating;
    step("add_set", 1, 1, 3'b001, 3'd0, 1, 1, 32'hFFFF_FFFF, 32'd2, 5'd0, {1'b1, 32'd1});
    step("shift_no_en", 1, 1, 3'b000, 3'd0, 1, 0, 32'h0000_0F00, 32'd0, 5'd1, {1'b1, 32'd1});
    step("shift_op101", 1, 1, 3'b000, 3'd5, 1, 1, 32'h0000_0F00, 32'd0, 5'd1, {1'b1, 32'd1});
    step("opsel010", 1, 1, 3'b010, 3'd0, 1, 1, 32'd8, 32'd8, 5'd0, {1'b1, 32'd1});
    step("arith_no_en", 1, 1, 3'b001, 3'd0, 0, 1, 32'd8, 32'd8, 5'd0, {1'b1, 32'd1});
  endtask

  task automatic test_mem;
    step("mem_read", 1, 1, 3'b101, 3'd2, 1, 0, 32'h0000_1000, 32'hFFFF_FFFC, 5'd0, {1'b0, 32'h0000_0FFC});
  endtask

  task automatic test_back_to_back;
    step("b2b_mem_write", 1, 1, 3'b100, 3'd7, 1, 0, 32'h0000_0100, 32'h0000_0023, 5'd0, {1'b0, 32'h0000_0123});
    step("b2b_xor", 1, 1, 3'b001, 3'd6, 1, 0, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, {1'b0, 32'h5555_5555});
  endtask

  task automatic test_random;
    logic [32:0] prev;
    logic [2:0]  os, op;
    logic        ex, ea, es;
    logic [31:0] a, b;
    logic [4:0]  n;
    for (int i = 0; i < 60; i++) begin
      prev = last_exp;
      ex = ($urandom_range(0, 7) != 0);
      os = 3'($urandom_range(0, 7));
      op = 3'($urandom_range(0, 7));
      ea = 1'($urandom);
      es = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      n  = 5'($urandom);
      step("random", 1, ex, os, op, ea, es, a, b, n, ref_alu(1'b1, ex, os, op, ea, es, a, b, n, prev));
    end
  endtask

  initial begin
    rst = 0; enable_ex = 0; opselect = 0; operation = 0;
    enable_arith = 0; enable_shift = 0; aluin1 = 0; aluin2 = 0; shift_number = 0;
    test_reset;
    test_carry;
    test_hadd_lhg;
    test_shift;
    test_gating;
    test_mem;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
